// File: rtl/hist_readout_ctrl_pkg.sv
// Shared definitions for the histogram readout path and the counter block.
// Holds op codes, the frame header base, the readout FSM state encoding and
// the default histogram sizes so both sides agree on bin counts.
package hist_readout_ctrl_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_HISTO = 2'd1;
  localparam logic [1:0] OP_IPI   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  localparam int HISTO_N_DEF    = 8;
  localparam int IPI_N_DEF      = 64;
  // Must cover the counter's clear sweep: at least IPI_N + 2.
  localparam int CLEAR_WAIT_DEF = 72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_LATCH,
    ST_SEND,
    ST_CLEAR,
    ST_CLRWAIT
  } state_t;

  // Frame header: the host resyncs on 0xA1 / 0xA2.
  function automatic logic [7:0] hdr_byte(input logic [1:0] op);
    return HDR_BASE | {6'd0, op};
  endfunction

endpackage

// File: rtl/hist_readout_ctrl_if.sv
// Bundle of command, read-mux, TX byte and clear signals around the readout FSM.
// master: the readout controller; slave: host decoder, read mux, TX FIFO, counter.
// Ports: cmd_valid/cmd/cmd_ready, rd_sel/rd_addr/rd_data, tx_data/tx_valid/tx_ready, resethist, busy.
interface hist_readout_ctrl_if;

  logic        cmd_valid;
  logic [2:0]  cmd;
  logic        cmd_ready;
  logic        rd_sel;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        resethist;
  logic        busy;

  modport master (
    input  cmd_valid, cmd, rd_data, tx_ready,
    output cmd_ready, rd_sel, rd_addr, tx_data, tx_valid, resethist, busy
  );

  modport slave (
    output cmd_valid, cmd, rd_data, tx_ready,
    input  cmd_ready, rd_sel, rd_addr, tx_data, tx_valid, resethist, busy
  );

endinterface

// File: rtl/hist_word_serializer.sv
// Splits a loaded 32-bit bin into 4 bytes, LSB first, with a done pulse on the last.
// Latency: first byte valid the cycle after load; one byte per cycle with ready high.
// Backpressure: byte held stable while byte_vld && !byte_rdy, indefinitely.
// Ports: clkin/reset, load/word in, byte_vld/byte_dat/byte_rdy out stream, done.
module hist_word_serializer (
  input  logic        clkin,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  output logic        byte_vld,
  output logic [7:0]  byte_dat,
  input  logic        byte_rdy,
  output logic        done
);

  logic [31:0] sh_q;
  logic [1:0]  idx_q;
  logic        act_q;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      idx_q <= '0;
      act_q <= 1'b0;
    end else if (load) begin
      sh_q  <= word;
      idx_q <= '0;
      act_q <= 1'b1;
    end else if (act_q && byte_rdy) begin
      sh_q  <= {8'd0, sh_q[31:8]};
      idx_q <= idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        act_q <= 1'b0;
      end
    end
  end

  assign byte_vld = act_q;
  assign byte_dat = sh_q[7:0];
  // Pulses in the cycle whose transfer completes byte 3.
  assign done     = act_q && byte_rdy && (idx_q == 2'd3);

endmodule

// File: rtl/hist_readout_ctrl.sv
// Walks the hit or IPI histogram through the registered read mux and frames each bin as bytes.
// Latency: header valid 1 cycle after accept; 6 cycles per bin with tx_ready high.
// Backpressure: stalls indefinitely on !tx_ready with tx_data held; commands dropped while busy.
// Ports: clkin, reset (async, active high), bus (hist_readout_ctrl_if.master).
module hist_readout_ctrl
  import hist_readout_ctrl_pkg::*;
#(
  parameter int HISTO_N    = HISTO_N_DEF,
  parameter int IPI_N      = IPI_N_DEF,
  parameter int CLEAR_WAIT = CLEAR_WAIT_DEF
) (
  input  logic clkin,
  input  logic reset,
  hist_readout_ctrl_if.master bus
);

  localparam int          WW         = $clog2(CLEAR_WAIT + 1);
  localparam logic [5:0]  HISTO_LAST = 6'(HISTO_N - 1);
  localparam logic [5:0]  IPI_LAST   = 6'(IPI_N - 1);

  state_t          state_q, state_d;
  logic [5:0]      bin_q, bin_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [1:0]      op_q, op_d;
  logic            clr_q, clr_d;
  logic [5:0]      bin_last;

  logic            ser_load;
  logic            ser_vld;
  logic [7:0]      ser_dat;
  logic            ser_done;

  hist_word_serializer u_ser (
    .clkin    (clkin),
    .reset    (reset),
    .load     (ser_load),
    .word     (bus.rd_data),
    .byte_vld (ser_vld),
    .byte_dat (ser_dat),
    .byte_rdy (bus.tx_ready),
    .done     (ser_done)
  );

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      wait_q  <= '0;
      op_q    <= OP_NOP;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      clr_q   <= clr_d;
    end
  end

  assign bin_last = (op_q == OP_IPI) ? IPI_LAST : HISTO_LAST;

  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    wait_d        = wait_q;
    op_d          = op_q;
    clr_d         = clr_q;
    ser_load      = 1'b0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'd0;
    bus.resethist = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd[1:0])
            OP_HISTO, OP_IPI: begin
              op_d    = bus.cmd[1:0];
              clr_d   = bus.cmd[2];
              bin_d   = '0;
              state_d = ST_HDR;
            end
            OP_CLEAR: state_d = ST_CLEAR;
            default:  ;
          endcase
        end
      end
      ST_HDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = hdr_byte(op_q);
        if (bus.tx_ready) begin
          state_d = ST_ADDR;
        end
      end
      // rd_sel/rd_addr are driven from op_q/bin_q continuously, so the
      // address is already stable here; the mux registers it this edge.
      ST_ADDR: state_d = ST_LATCH;
      ST_LATCH: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        bus.tx_valid = ser_vld;
        bus.tx_data  = ser_dat;
        if (ser_done) begin
          if (bin_q < bin_last) begin
            bin_d   = bin_q + 6'd1;
            state_d = ST_ADDR;
          end else if (clr_q) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CLEAR: begin
        bus.resethist = 1'b1;
        wait_d        = WW'(CLEAR_WAIT);
        state_d       = ST_CLRWAIT;
      end
      ST_CLRWAIT: begin
        // CLRWAIT lasts exactly CLEAR_WAIT cycles; IDLE is entered with the counter at 0.
        if (wait_q <= WW'(1)) begin
          wait_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rd_sel    = (op_q == OP_IPI);
  assign bus.rd_addr   = bin_q;

endmodule

// File: tb/tb_hist_readout_ctrl.sv
// Directed bench for hist_readout_ctrl: framing, sweeps, clear hold-off, stalls, reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the falling edge.
// Ports: drives the slave side of hist_readout_ctrl_if and models the registered read mux.
module tb_hist_readout_ctrl;

  logic clkin = 1'b0;
  logic reset = 1'b1;
  always #5 clkin = ~clkin;

  hist_readout_ctrl_if bus ();

  hist_readout_ctrl dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] histo_mem [0:7];
  logic [31:0] ipi_mem   [0:63];

  // External registered read mux: data valid one cycle after address.
  always @(posedge clkin)
    bus.rd_data <= bus.rd_sel ? ipi_mem[bus.rd_addr] : histo_mem[bus.rd_addr[2:0]];

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  bit rnd_ready = 1'b0;
  always @(posedge clkin) begin
    if (rnd_ready) begin
      #1;
      bus.tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: captures transferred bytes, stall stability, resethist pulses, address sweep.
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  logic [5:0] addr_q [$];
  int   last_xfer_cyc = 0;
  int   stall_viol = 0, stall_cnt = 0;
  int   rh_cnt = 0, rh_cyc = 0, rh_dbl = 0;
  int   sel0_cnt = 0, sel1_cnt = 0;
  bit   stall_pend = 1'b0, rh_prev = 1'b0;
  logic [7:0] stall_dat = 8'd0;

  always @(negedge clkin) begin
    if (!reset) begin
      if (bus.tx_valid && bus.tx_ready) begin
        got_q.push_back(bus.tx_data);
        last_xfer_cyc = cyc;
      end
      if (stall_pend && (!bus.tx_valid || bus.tx_data !== stall_dat)) stall_viol++;
      stall_pend = bus.tx_valid && !bus.tx_ready;
      if (stall_pend) stall_cnt++;
      stall_dat = bus.tx_data;
      if (bus.resethist) begin
        rh_cnt++;
        rh_cyc = cyc;
        if (rh_prev) rh_dbl++;
      end
      rh_prev = bus.resethist;
      if (bus.busy) begin
        if (bus.rd_sel) sel1_cnt++; else sel0_cnt++;
        if (addr_q.size() == 0 || addr_q[$] != bus.rd_addr) addr_q.push_back(bus.rd_addr);
      end
    end else begin
      stall_pend = 1'b0;
      rh_prev    = 1'b0;
    end
  end

  task automatic issue_cmd(input logic [2:0] c);
    @(posedge clkin); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    @(posedge clkin); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
  endtask

  task automatic wait_idle(input int budget, output int idle_at, output int busy_cnt,
                           output bit ok);
    ok = 1'b0; idle_at = 0; busy_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clkin); #1;
      if (!bus.busy) begin
        ok = 1'b1;
        idle_at = cyc;
        break;
      end
      busy_cnt++;
    end
  endtask

  task automatic build_exp(input bit ipi);
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(ipi ? 8'hA2 : 8'hA1);
    for (int b = 0; b < (ipi ? 64 : 8); b++) begin
      w = ipi ? ipi_mem[b] : histo_mem[b];
      for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
    end
  endtask

  // Returns the number of differing bytes; reports the first difference.
  function automatic int stream_diff(output int idx, output logic [7:0] g,
                                     output logic [7:0] e);
    int n = 0;
    logic [7:0] gb;
    idx = -1; g = 8'd0; e = 8'd0;
    for (int i = 0; i < exp_q.size(); i++) begin
      gb = (i < got_q.size()) ? got_q[i] : 8'hxx;
      if (gb !== exp_q[i]) begin
        if (idx < 0) begin idx = i; g = gb; e = exp_q[i]; end
        n++;
      end
    end
    if (got_q.size() > exp_q.size()) n += got_q.size() - exp_q.size();
    return n;
  endfunction

  task automatic test_reset;
    #1;
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    vectors++;
    if ({bus.busy, bus.tx_valid, bus.resethist, bus.rd_sel} !== 4'b0000) begin miscompares++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.busy, bus.tx_valid, bus.resethist, bus.rd_sel}); end
    vectors++;
    if ({bus.rd_addr, bus.tx_data} !== 14'd0) begin miscompares++;
      $display("FAIL reset_addr_data got %h/%h want 00/00", bus.rd_addr, bus.tx_data); end
    repeat (2) @(posedge clkin);
    #1 reset = 1'b0;
  endtask

  task automatic test_histo_read;
    int idle_at, busy_cnt, nd, idx; bit ok; logic [7:0] g, e;
    got_q.delete();
    build_exp(1'b0);
    issue_cmd(3'b001);
    @(negedge clkin); #1;
    vectors++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA1) begin miscompares++;
      $display("FAIL histo_hdr_latency got v=%b d=%h want v=1 d=a1", bus.tx_valid, bus.tx_data); end
    wait_idle(500, idle_at, busy_cnt, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL histo_timeout busy still 1 want 0"); end
    vectors++;
    if (got_q.size() !== 33) begin miscompares++;
      $display("FAIL histo_len got %0d want 33", got_q.size()); end
    vectors++;
    if ((got_q.size() > 5 ? got_q[5] : 8'hxx) !== 8'h01) begin miscompares++;
      $display("FAIL histo_bin1_byte0 got %h want 01", got_q.size() > 5 ? got_q[5] : 8'hxx); end
    nd = stream_diff(idx, g, e);
    vectors++;
    if (nd !== 0) begin miscompares++;
      $display("FAIL histo_stream %0d bad bytes, first at %0d got %h want %h", nd, idx, g, e); end
    // Header cycle was consumed above; remaining 8 bins at 6 cycles each.
    vectors++;
    if (busy_cnt !== 48) begin miscompares++;
      $display("FAIL histo_cycles got %0d want 48", busy_cnt); end
    vectors++;
    if (idle_at !== last_xfer_cyc + 1) begin miscompares++;
      $display("FAIL histo_busy_drop got %0d want %0d", idle_at - last_xfer_cyc, 1); end
  endtask

  task automatic test_ipi_read;
    int idle_at, busy_cnt, nd, idx, bad_addr; bit ok; logic [7:0] g, e; logic [31:0] tail;
    got_q.delete(); addr_q.delete(); sel0_cnt = 0; sel1_cnt = 0;
    build_exp(1'b1);
    issue_cmd(3'b010);
    wait_idle(2000, idle_at, busy_cnt, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ipi_timeout busy still 1 want 0"); end
    vectors++;
    if (got_q.size() !== 257) begin miscompares++;
      $display("FAIL ipi_len got %0d want 257", got_q.size()); end
    tail = (got_q.size() == 257) ? {got_q[256], got_q[255], got_q[254], got_q[253]} : 32'hxxxxxxxx;
    vectors++;
    if (tail !== 32'h12345678) begin miscompares++;
      $display("FAIL ipi_tail got %h want 12345678", tail); end
    nd = stream_diff(idx, g, e);
    vectors++;
    if (nd !== 0) begin miscompares++;
      $display("FAIL ipi_stream %0d bad bytes, first at %0d got %h want %h", nd, idx, g, e); end
    bad_addr = (addr_q.size() == 64) ? 0 : 1;
    foreach (addr_q[i]) if (addr_q[i] !== 6'(i)) bad_addr++;
    vectors++;
    if (bad_addr !== 0) begin miscompares++;
      $display("FAIL ipi_addr_sweep got %0d addrs (%0d wrong) want 0..63", addr_q.size(), bad_addr); end
    vectors++;
    if (sel0_cnt !== 0 || sel1_cnt !== 385) begin miscompares++;
      $display("FAIL ipi_rd_sel got sel0=%0d sel1=%0d want 0/385", sel0_cnt, sel1_cnt); end
  endtask

  task automatic test_clear_after;
    int idle_at, busy_cnt, rh0; bit ok;
    got_q.delete();
    rh0 = rh_cnt;
    issue_cmd(3'b101);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clkin); #1;
      if (rh_cnt != rh0) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL clr_pulse_timeout got none want 1"); end
    vectors++;
    if (rh_cyc !== last_xfer_cyc + 1 || got_q.size() !== 33) begin miscompares++;
      $display("FAIL clr_pulse_pos got delta=%0d len=%0d want 1/33",
               rh_cyc - last_xfer_cyc, got_q.size()); end
    // A clear presented during the hold-off must be dropped.
    @(posedge clkin); #1;
    bus.cmd_valid = 1'b1; bus.cmd = 3'b011;
    repeat (10) @(posedge clkin);
    #1 bus.cmd_valid = 1'b0; bus.cmd = 3'd0;
    wait_idle(500, idle_at, busy_cnt, ok);
    vectors++;
    if (!ok || idle_at - rh_cyc - 1 !== 72) begin miscompares++;
      $display("FAIL clr_holdoff got %0d cycles want 72", idle_at - rh_cyc - 1); end
    repeat (3) @(negedge clkin);
    vectors++;
    if (rh_cnt - rh0 !== 1 || rh_dbl !== 0) begin miscompares++;
      $display("FAIL clr_single got %0d pulses (%0d double) want 1/0", rh_cnt - rh0, rh_dbl); end
  endtask

  task automatic test_clear_cmd_and_nop;
    int idle_at, busy_cnt, rh0; bit ok;
    got_q.delete();
    issue_cmd(3'b000);
    @(negedge clkin); #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || got_q.size() !== 0) begin miscompares++;
      $display("FAIL nop_action got busy=%b v=%b bytes=%0d want 0/0/0",
               bus.busy, bus.tx_valid, got_q.size()); end
    rh0 = rh_cnt;
    issue_cmd(3'b011);
    @(negedge clkin); #1;
    vectors++;
    if (bus.resethist !== 1'b1) begin miscompares++;
      $display("FAIL clear_cmd_pulse got %b want 1", bus.resethist); end
    wait_idle(200, idle_at, busy_cnt, ok);
    vectors++;
    if (!ok || busy_cnt !== 72 || rh_cnt - rh0 !== 1) begin miscompares++;
      $display("FAIL clear_cmd_wait got busy=%0d pulses=%0d want 72/1", busy_cnt, rh_cnt - rh0); end
  endtask

  task automatic test_stall;
    int idle_at, busy_cnt, nd, idx; bit ok; logic [7:0] g, e;
    got_q.delete(); stall_viol = 0; stall_cnt = 0;
    build_exp(1'b1);
    rnd_ready = 1'b1;
    issue_cmd(3'b010);
    wait_idle(6000, idle_at, busy_cnt, ok);
    rnd_ready = 1'b0;
    bus.tx_ready = 1'b1;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stall_timeout busy still 1 want 0"); end
    nd = stream_diff(idx, g, e);
    vectors++;
    if (nd !== 0 || got_q.size() !== 257) begin miscompares++;
      $display("FAIL stall_stream %0d bad, len %0d, first at %0d got %h want %h",
               nd, got_q.size(), idx, g, e); end
    vectors++;
    if (stall_viol !== 0) begin miscompares++;
      $display("FAIL stall_hold got %0d unstable cycles want 0", stall_viol); end
    vectors++;
    if (stall_cnt == 0) begin miscompares++;
      $display("FAIL stall_exercised got 0 stall cycles want >0"); end
  endtask

  task automatic test_cmd_while_busy;
    int idle_at, busy_cnt, nd, idx; bit ok; logic [7:0] g, e;
    got_q.delete();
    build_exp(1'b0);
    issue_cmd(3'b001);
    for (int i = 0; i < 100 && got_q.size() < 6; i++) begin @(negedge clkin); #1; end
    @(posedge clkin); #1;
    bus.cmd_valid = 1'b1; bus.cmd = 3'b001;
    repeat (20) @(posedge clkin);
    #1 bus.cmd_valid = 1'b0; bus.cmd = 3'd0;
    wait_idle(500, idle_at, busy_cnt, ok);
    repeat (4) @(negedge clkin);
    nd = stream_diff(idx, g, e);
    vectors++;
    if (!ok || nd !== 0 || got_q.size() !== 33) begin miscompares++;
      $display("FAIL busy_drop_cmd %0d bad, len %0d want 0/33", nd, got_q.size()); end
  endtask

  task automatic test_reset_mid_frame;
    int idle_at, busy_cnt, nd, idx; bit ok; logic [7:0] g, e;
    got_q.delete();
    issue_cmd(3'b010);
    for (int i = 0; i < 100 && got_q.size() < 10; i++) begin @(negedge clkin); #1; end
    @(posedge clkin); #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.tx_valid, bus.resethist, bus.busy, bus.cmd_ready} !== 4'b0001) begin miscompares++;
      $display("FAIL mid_reset_outputs got %b want 0001",
               {bus.tx_valid, bus.resethist, bus.busy, bus.cmd_ready}); end
    repeat (2) @(posedge clkin);
    #1 reset = 1'b0;
    got_q.delete();
    build_exp(1'b0);
    issue_cmd(3'b001);
    wait_idle(500, idle_at, busy_cnt, ok);
    nd = stream_diff(idx, g, e);
    vectors++;
    if (!ok || nd !== 0 || got_q.size() !== 33) begin miscompares++;
      $display("FAIL post_reset_frame %0d bad, len %0d, first at %0d got %h want %h",
               nd, got_q.size(), idx, g, e); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
    bus.tx_ready  = 1'b1;
    for (int i = 0; i < 8; i++) histo_mem[i] = 32'(i) * 32'h01010101;
    for (int i = 0; i < 64; i++) ipi_mem[i] = 32'hC0DE0000 | (32'(i) * 32'd3);
    ipi_mem[63] = 32'h12345678;

    test_reset();
    test_histo_read();
    test_ipi_read();
    test_clear_after();
    test_clear_cmd_and_nop();
    test_stall();
    test_cmd_while_busy();
    test_reset_mid_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
